// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter and sequencer in front of mem_controller.
// Round-robin on ties, registered outputs, watchdog abort on a stuck request.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_is_write,
  input  logic [2:0]  d_num_bytes,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_start_request,
  output logic        mem_is_write,
  output logic [2:0]  mem_num_bytes,
  output logic [31:0] mem_target_address,
  output logic [31:0] mem_write_value,
  output logic        mem_is_data_fetch,
  input  logic [31:0] mem_fetched_data,
  input  logic        mem_request_done
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic        last_d;
  logic        gnt_d;
  logic [15:0] cnt;
  logic        grant_d;
  logic        timeout;

  // D wins only if I is idle or I had the previous grant
  assign grant_d = d_req & (~i_req | ~last_d);

  // Abort at the edge that would complete TIMEOUT_CYCLES ISSUE cycles
  assign timeout = (TO_LIM != 17'd0) &&
                   (({1'b0, cnt} + 17'd1) == TO_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      last_d             <= 1'b1;
      gnt_d              <= 1'b0;
      cnt                <= '0;
      i_ack              <= 1'b0;
      d_ack              <= 1'b0;
      err                <= 1'b0;
      i_rdata            <= '0;
      d_rdata            <= '0;
      mem_start_request  <= 1'b0;
      mem_is_write       <= 1'b0;
      mem_num_bytes      <= '0;
      mem_target_address <= '0;
      mem_write_value    <= '0;
      mem_is_data_fetch  <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req | d_req) begin
            state             <= ISSUE;
            mem_start_request <= 1'b1;
            cnt               <= '0;
            gnt_d             <= grant_d;
            last_d            <= grant_d;
            mem_is_data_fetch <= grant_d;
            if (grant_d) begin
              mem_is_write       <= d_is_write;
              mem_num_bytes      <= d_num_bytes;
              mem_target_address <= d_addr;
              mem_write_value    <= d_wdata;
            end else begin
              mem_is_write       <= 1'b0;
              mem_num_bytes      <= 3'd4;
              mem_target_address <= i_addr;
              mem_write_value    <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_request_done) begin
            state             <= RELEASE;
            mem_start_request <= 1'b0;
            if (gnt_d) begin
              d_rdata <= mem_fetched_data;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= mem_fetched_data;
              i_ack   <= 1'b1;
            end
          end else if (timeout) begin
            state             <= RELEASE;
            mem_start_request <= 1'b0;
            err               <= 1'b1;
            if (gnt_d) begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end else begin
              i_rdata <= '0;
              i_ack   <= 1'b1;
            end
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle
// sequences for round-robin, timeout, reset and withdrawn requests.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_is_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_num_bytes;
  logic        i_ack, d_ack, err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_start_request, mem_is_write, mem_is_data_fetch;
  logic [2:0]  mem_num_bytes;
  logic [31:0] mem_target_address, mem_write_value;
  logic [31:0] mem_fetched_data;
  logic        mem_request_done;

  logic        t_i_req;
  logic [31:0] t_i_addr;
  logic        t_i_ack, t_d_ack, t_err;
  logic [31:0] t_i_rdata, t_d_rdata;
  logic        t_start, t_wr, t_dfetch;
  logic [2:0]  t_nb;
  logic [31:0] t_addr, t_wval;
  logic [31:0] t_fetched;
  logic        t_done;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_is_write(d_is_write),
    .d_num_bytes(d_num_bytes), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack),
    .d_rdata(d_rdata), .err(err),
    .mem_start_request(mem_start_request),
    .mem_is_write(mem_is_write),
    .mem_num_bytes(mem_num_bytes),
    .mem_target_address(mem_target_address),
    .mem_write_value(mem_write_value),
    .mem_is_data_fetch(mem_is_data_fetch),
    .mem_fetched_data(mem_fetched_data),
    .mem_request_done(mem_request_done)
  );

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rst(rst),
    .i_req(t_i_req), .i_addr(t_i_addr),
    .i_ack(t_i_ack), .i_rdata(t_i_rdata),
    .d_req(1'b0), .d_is_write(1'b0),
    .d_num_bytes(3'd0), .d_addr(32'd0),
    .d_wdata(32'd0), .d_ack(t_d_ack),
    .d_rdata(t_d_rdata), .err(t_err),
    .mem_start_request(t_start),
    .mem_is_write(t_wr),
    .mem_num_bytes(t_nb),
    .mem_target_address(t_addr),
    .mem_write_value(t_wval),
    .mem_is_data_fetch(t_dfetch),
    .mem_fetched_data(t_fetched),
    .mem_request_done(t_done)
  );

  typedef struct {
    logic        ir, dr, wr;
    logic [2:0]  nb;
    logic [31:0] ia, da, wd, rd;
    int          lat;
    logic        exp_d;
  } vec_t;

  vec_t vt[6];
  int total = 0;
  int bad = 0;
  logic [31:0] mi, md;
  logic [68:0] fexp;
  int acks, n, hi;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_start(input string nm);
    for (int k = 0; k < 20 && !mem_start_request; k++)
      @(negedge clk);
    if (!mem_start_request) chk(nm, 0, 1);
  endtask

  task automatic t_txn(input logic [31:0] data);
    t_i_req = 1'b1;
    for (int k = 0; k < 20 && !t_start; k++) @(negedge clk);
    if (!t_start) chk("to_start", 0, 1);
    repeat (2) @(negedge clk);
    t_fetched = data;
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    t_i_req = 1'b0;
    chk("to_norm", {t_i_ack, t_err, t_i_rdata},
        {1'b1, 1'b0, data});
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctl"},
        {i_ack, d_ack, err, mem_start_request, mem_is_write,
         mem_num_bytes, mem_is_data_fetch, mem_target_address,
         mem_write_value}, 0);
    chk({nm, "_rd"}, {i_rdata, d_rdata}, 0);
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0,
              32'h0, 32'hDEAD_BEEF, 20, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b1, 3'd2, 32'h0, 32'h0100_0004,
              32'h0000_1234, 32'h0, 5, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 3'd4, 32'h0, 32'h2000_0008,
              32'h0, 32'hCAFE_F00D, 3, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 3'd4, 32'h0000_0040,
              32'h3000_0000, 32'h0, 32'h1122_3344, 4, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 3'd1, 32'h0000_0044,
              32'h3000_0010, 32'h0000_00AB, 32'h5566_7788, 2, 1'b1};
    vt[5] = '{1'b0, 1'b1, 1'b0, 3'd3, 32'h0, 32'h3000_0020,
              32'hFFFF_FFFF, 32'h99AA_BBCC, 1, 1'b1};

    rst = 1'b1;
    i_req = 0; d_req = 0; d_is_write = 0; d_num_bytes = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_fetched_data = 0; mem_request_done = 0;
    t_i_req = 0; t_i_addr = 32'h0000_0080;
    t_fetched = 0; t_done = 0;
    mi = 0; md = 0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    chk("reset_to", {t_i_ack, t_err, t_start, t_i_rdata}, 0);
    rst = 1'b0;

    // done while idle must be ignored
    mem_request_done = 1'b1;
    @(negedge clk);
    mem_request_done = 1'b0;
    chk("idle_done", {i_ack, d_ack, err, mem_start_request}, 0);
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      i_req = vt[i].ir; i_addr = vt[i].ia;
      d_req = vt[i].dr; d_is_write = vt[i].wr;
      d_num_bytes = vt[i].nb; d_addr = vt[i].da;
      d_wdata = vt[i].wd;
      @(negedge clk);
      wait_start($sformatf("v%0d_start", i));
      fexp = vt[i].exp_d ?
        {vt[i].wr, vt[i].nb, vt[i].da, vt[i].wd, 1'b1} :
        {1'b0, 3'd4, vt[i].ia, 32'd0, 1'b0};
      chk($sformatf("v%0d_fields", i),
          {mem_is_write, mem_num_bytes, mem_target_address,
           mem_write_value, mem_is_data_fetch}, fexp);
      acks = 0;
      repeat (vt[i].lat) begin
        @(negedge clk);
        acks += int'(i_ack | d_ack);
      end
      chk($sformatf("v%0d_noack", i), acks, 0);
      mem_fetched_data = vt[i].rd;
      mem_request_done = 1'b1;
      @(negedge clk);
      mem_request_done = 1'b0;
      i_req = 0; d_req = 0;
      if (vt[i].exp_d) md = vt[i].rd;
      else mi = vt[i].rd;
      chk($sformatf("v%0d_ack", i),
          {i_ack, d_ack, err, mem_start_request},
          vt[i].exp_d ? 4'b0100 : 4'b1000);
      chk($sformatf("v%0d_rdata", i), {i_rdata, d_rdata}, {mi, md});
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {i_ack, d_ack}, 0);
    end

    // tie held from reset: I, D, I, D with RELEASE+IDLE gap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mi = 0; md = 0;
    i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
    d_is_write = 0; d_num_bytes = 3'd4;
    @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      wait_start($sformatf("rr%0d_start", t));
      chk($sformatf("rr%0d_order", t), mem_is_data_fetch, t % 2);
      repeat (3) @(negedge clk);
      mem_fetched_data = 32'h100 + t;
      mem_request_done = 1'b1;
      @(negedge clk);
      mem_request_done = 1'b0;
      chk($sformatf("rr%0d_ack", t), {i_ack, d_ack},
          (t % 2) ? 2'b01 : 2'b10);
      if (t < 3) begin
        n = 0;
        while (!mem_start_request && n < 10) begin
          n++;
          @(negedge clk);
        end
        chk($sformatf("rr%0d_gap", t), n, 2);
      end
    end
    i_req = 0; d_req = 0;
    repeat (2) @(negedge clk);

    // watchdog on the TIMEOUT_CYCLES=8 instance
    t_txn(32'hA5A5_A5A5);
    t_i_req = 1'b1;
    for (int k = 0; k < 20 && !t_start; k++) @(negedge clk);
    hi = 0;
    while (t_start && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    t_i_req = 1'b0;
    chk("to_cycles", hi, 8);
    chk("to_ack", {t_i_ack, t_err, t_d_ack, t_i_rdata},
        {1'b1, 1'b1, 1'b0, 32'h0});
    @(negedge clk);
    chk("to_pulse", {t_i_ack, t_err, t_start}, 0);
    t_txn(32'h1111_2222);

    // reset 5 cycles into a D load
    d_req = 1; d_is_write = 0; d_num_bytes = 3'd4;
    d_addr = 32'h0400_0000;
    @(negedge clk);
    wait_start("rst_start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    d_req = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("rst_mid");
    acks = 0;
    mem_request_done = 1'b1;
    repeat (5) begin
      @(negedge clk);
      mem_request_done = 1'b0;
      acks += int'(i_ack | d_ack | err);
    end
    chk("rst_noack", acks, 0);
    i_req = 1; d_req = 1; i_addr = 32'h0000_0500;
    @(negedge clk);
    wait_start("rst_tie_start");
    chk("rst_tie_i", {mem_is_data_fetch, mem_target_address},
        {1'b0, 32'h0000_0500});
    repeat (2) @(negedge clk);
    mem_fetched_data = 32'h7777_0000;
    mem_request_done = 1'b1;
    @(negedge clk);
    mem_request_done = 1'b0;
    i_req = 0; d_req = 0;
    chk("rst_tie_ack", {i_ack, d_ack, i_rdata},
        {2'b10, 32'h7777_0000});
    repeat (2) @(negedge clk);

    // D withdraws its request mid-transaction, I waits
    d_req = 1; d_addr = 32'h0500_0000;
    @(negedge clk);
    wait_start("wd_start");
    chk("wd_grant_d", mem_is_data_fetch, 1);
    i_req = 1; i_addr = 32'h0000_0600;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(i_ack | d_ack);
    end
    d_req = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(i_ack | d_ack);
    end
    chk("wd_early", acks, 0);
    mem_fetched_data = 32'h0BAD_F00D;
    mem_request_done = 1'b1;
    @(negedge clk);
    mem_request_done = 1'b0;
    chk("wd_ack", {i_ack, d_ack, err, d_rdata},
        {3'b010, 32'h0BAD_F00D});
    n = 0;
    acks = 0;
    while (!mem_start_request && n < 10) begin
      n++;
      @(negedge clk);
      acks += int'(d_ack);
    end
    chk("wd_gap", n, 2);
    chk("wd_once", acks, 0);
    chk("wd_i_next", {mem_is_data_fetch, mem_target_address},
        {1'b0, 32'h0000_0600});
    repeat (2) @(negedge clk);
    mem_fetched_data = 32'h0600_0600;
    mem_request_done = 1'b1;
    @(negedge clk);
    mem_request_done = 1'b0;
    i_req = 0;
    chk("wd_i_ack", {i_ack, d_ack, i_rdata},
        {2'b10, 32'h0600_0600});
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
